// File: rtl/bin_to_display_number_pkg.sv
// Shared types and constants for the binary-to-BCD display path (package display_pkg).
// Provides the converter state enum and the leading-zero blanking helper.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int          DIGITS       = 4;
    localparam logic [15:0] BCD_MAX      = 16'h9999;
    localparam int unsigned BCD_MAX_BIN  = 9999;
    localparam logic [3:0]  BLANK_NIBBLE = 4'hF;

    // Blank zero digits from thousands downward until the first non-zero digit; units always shown.
    function automatic logic [15:0] blank_leading_zeros(input logic [15:0] value);
        logic [15:0] result;
        logic        blanking;
        result   = value;
        blanking = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (blanking && (value[d*4 +: 4] == 4'h0)) begin
                result[d*4 +: 4] = BLANK_NIBBLE;
            end else begin
                blanking = 1'b0;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bin_to_display_number_if.sv
// Handshake and result bundle between a binary producer and the BCD converter.
interface bin_to_display_number_if #(
    parameter int BIN_WIDTH = 14
);
    logic [BIN_WIDTH-1:0] bin_in;
    logic                 in_valid;
    logic                 in_ready;
    logic [15:0]          display_number;
    logic                 out_valid;
    logic                 overflow;

    modport master (
        output bin_in, in_valid,
        input  in_ready, display_number, out_valid, overflow
    );

    modport slave (
        input  bin_in, in_valid,
        output in_ready, display_number, out_valid, overflow
    );
endinterface

// File: rtl/bcd_adjust_digit.sv
// Single-digit correction step of shift-and-add-3: adds 3 when the digit is 5 or more.
module bcd_adjust_digit (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);
    assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;
endmodule

// File: rtl/bin_to_display_number.sv
// Sequential binary-to-BCD converter feeding the 4-digit display; saturates at 9999.
// Optional macro LEADING_ZERO_BLANK_EN replaces leading zero digits with the blank code.
module bin_to_display_number
    import display_pkg::*;
#(
    parameter int BIN_WIDTH = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bin_to_display_number_if.slave  bus
);
    localparam int                CNT_W     = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(BIN_WIDTH - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [BIN_WIDTH-1:0]   shreg_q, shreg_d;
    logic [15:0]            scratch_q, scratch_d;
    logic                   ovf_q, ovf_d;
    logic [15:0]            display_q, display_d;
    logic                   overflow_q, overflow_d;

    logic [15:0]            adjusted;
    logic [15:0]            shifted;
    logic [15:0]            result_value;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
        bcd_adjust_digit u_adjust (
            .digit_in  (scratch_q[g*4 +: 4]),
            .digit_out (adjusted[g*4 +: 4])
        );
    end

    // Top adjusted bit falls off; the next binary bit enters the units digit.
    assign shifted = {adjusted[14:0], shreg_q[BIN_WIDTH-1]};

`ifdef LEADING_ZERO_BLANK_EN
    assign result_value = ovf_q ? BCD_MAX : blank_leading_zeros(shifted);
`else
    assign result_value = ovf_q ? BCD_MAX : shifted;
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        ovf_d      = ovf_q;
        display_d  = display_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d   = SHIFT;
                    shreg_d   = bus.bin_in;
                    scratch_d = 16'h0000;
                    count_d   = '0;
                    ovf_d     = (32'(bus.bin_in) > BCD_MAX_BIN);
                end
            end
            SHIFT: begin
                scratch_d = shifted;
                shreg_d   = shreg_q << 1;
                if (count_q == LAST_ITER) begin
                    state_d    = DONE;
                    display_d  = result_value;
                    overflow_d = ovf_q;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            shreg_q    <= '0;
            scratch_q  <= 16'h0000;
            ovf_q      <= 1'b0;
            display_q  <= 16'h0000;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            ovf_q      <= ovf_d;
            display_q  <= display_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.in_ready       = (state_q == IDLE);
    assign bus.out_valid      = (state_q == DONE);
    assign bus.display_number = display_q;
    assign bus.overflow       = overflow_q;

endmodule
